wb_gpio_bank: RTL and testbench

//  Parametrised Wishbone-classic GPIO bank: NUM_PINS pins, per-pin direction, atomic set/clr/toggle,
//  N-stage input synchroniser, optional edge-triggered interrupt. Wishbone slave next to the other

---
 rtl/wb_gpio_bank.sv | 162 ++++++++++++++++
 tb/tb_wb_gpio_bank.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_gpio_bank.sv
// Wishbone-classic GPIO bank: per-pin direction, atomic set/clr/toggle, synchronised inputs.
// Define GPIO_IRQ_EN to build the edge-triggered interrupt logic (IRQ_RISE/IRQ_FALL/IRQ_STAT).
module wb_gpio_bank #(
  parameter int          NUM_PINS    = 8,
  parameter int          SYNC_STAGES = 2,
  parameter logic [31:0] OUT_RESET   = 32'h0,
  parameter logic [31:0] DIR_RESET   = 32'h0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         adr_i,
  input  logic [31:0]         dat_i,
  output logic [31:0]         dat_o,
  input  logic                we_i,
  input  logic [3:0]          sel_i,
  input  logic                stb_i,
  input  logic                cyc_i,
  output logic                ack_o,
  input  logic [NUM_PINS-1:0] gpio_i,
  output logic [NUM_PINS-1:0] gpio_o,
  output logic [NUM_PINS-1:0] gpio_oe_o,
  output logic                irq_o
);

  localparam int N = NUM_PINS;

  localparam logic [3:0] REG_IN  = 4'd0;
  localparam logic [3:0] REG_OUT = 4'd1;
  localparam logic [3:0] REG_DIR = 4'd2;
  localparam logic [3:0] REG_SET = 4'd3;
  localparam logic [3:0] REG_CLR = 4'd4;
  localparam logic [3:0] REG_TGL = 4'd5;
`ifdef GPIO_IRQ_EN
  localparam logic [3:0] REG_RISE = 4'd6;
  localparam logic [3:0] REG_FALL = 4'd7;
  localparam logic [3:0] REG_STAT = 4'd8;
`endif

  function automatic logic [31:0] zext(input logic [N-1:0] v);
    logic [31:0] r;
    r = '0;
    r[N-1:0] = v;
    return r;
  endfunction

  function automatic logic [N-1:0] lane_merge(input logic [N-1:0] old,
                                              input logic [N-1:0] d,
                                              input logic [N-1:0] m);
    return (old & ~m) | (d & m);
  endfunction

  logic           req;
  logic           wr;
  logic [3:0]     reg_sel;
  logic [N-1:0]   wdata;
  logic [31:0]    lane_mask;
  logic [31:0]    rdata;
  logic [N-1:0]   out_q, dir_q, out_nxt, dir_nxt;
  logic [N-1:0]   sync_q [SYNC_STAGES];
  logic [N-1:0]   in_val;
  logic           unused_bits;

  // A request already acknowledged this cycle is not served twice.
  assign req       = cyc_i & stb_i & ~ack_o;
  assign wr        = req & we_i;
  assign reg_sel   = adr_i[5:2];
  assign wdata     = dat_i[N-1:0];
  assign lane_mask = {{8{sel_i[3]}}, {8{sel_i[2]}}, {8{sel_i[1]}}, {8{sel_i[0]}}};
  assign in_val    = sync_q[SYNC_STAGES-1];
  assign gpio_o    = out_q;
  assign gpio_oe_o = dir_q;
  assign unused_bits = ^{adr_i[31:6], adr_i[1:0], dat_i, lane_mask};

  // Pad synchroniser chain
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= gpio_i;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

`ifdef GPIO_IRQ_EN
  logic [N-1:0] rise_q, fall_q, stat_q, prev_q, stat_nxt, ev;
  logic         irq_q;

  // Edge events use the masks as they stand before this edge's write.
  always_comb begin
    ev       = ((in_val & ~prev_q) & rise_q) | ((~in_val & prev_q) & fall_q);
    stat_nxt = stat_q;
    if (wr && reg_sel == REG_STAT) stat_nxt = stat_nxt & ~wdata;
    stat_nxt = stat_nxt | ev;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rise_q <= '0;
      fall_q <= '0;
      stat_q <= '0;
      prev_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      prev_q <= in_val;
      if (wr && reg_sel == REG_RISE) rise_q <= lane_merge(rise_q, wdata, lane_mask[N-1:0]);
      if (wr && reg_sel == REG_FALL) fall_q <= lane_merge(fall_q, wdata, lane_mask[N-1:0]);
      stat_q <= stat_nxt;
      irq_q  <= |stat_nxt;
    end
  end

  assign irq_o = irq_q;
`else
  assign irq_o = 1'b0;
`endif

  always_comb begin
    rdata = '0;
    case (reg_sel)
      REG_IN:   rdata = zext(in_val);
      REG_OUT:  rdata = zext(out_q);
      REG_DIR:  rdata = zext(dir_q);
`ifdef GPIO_IRQ_EN
      REG_RISE: rdata = zext(rise_q);
      REG_FALL: rdata = zext(fall_q);
      REG_STAT: rdata = zext(stat_q);
`endif
      default:  rdata = '0;
    endcase
  end

  always_comb begin
    out_nxt = out_q;
    dir_nxt = dir_q;
    if (wr) begin
      case (reg_sel)
        REG_OUT: out_nxt = lane_merge(out_q, wdata, lane_mask[N-1:0]);
        REG_DIR: dir_nxt = lane_merge(dir_q, wdata, lane_mask[N-1:0]);
        REG_SET: out_nxt = out_q | wdata;
        REG_CLR: out_nxt = out_q & ~wdata;
        REG_TGL: out_nxt = out_q ^ wdata;
        default: ;
      endcase
    end
  end

  // Bus response and register commit share one edge
  always_ff @(posedge clk) begin
    if (rst) begin
      ack_o <= 1'b0;
      dat_o <= '0;
      out_q <= OUT_RESET[N-1:0];
      dir_q <= DIR_RESET[N-1:0];
    end else begin
      ack_o <= req;
      dat_o <= req ? rdata : '0;
      out_q <= out_nxt;
      dir_q <= dir_nxt;
    end
  end

endmodule

// File: tb/tb_wb_gpio_bank.sv
// Bench for wb_gpio_bank (8 pins, 2 sync stages, OUT reset A5): directed steps then random traffic
// checked cycle by cycle against a register-level reference model.
module tb_wb_gpio_bank;

  localparam int SS = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] adr = '0;
  logic [31:0] dat_w = '0;
  logic [31:0] dat_r;
  logic        we = 1'b0;
  logic [3:0]  sel = '0;
  logic        stb = 1'b0;
  logic        cyc = 1'b0;
  logic        ack;
  logic [7:0]  pads = '0;
  logic [7:0]  gout, goe;
  logic        irq;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  wb_gpio_bank #(
    .NUM_PINS(8), .SYNC_STAGES(SS), .OUT_RESET(32'hA5), .DIR_RESET(32'h0)
  ) dut (
    .clk(clk), .rst(rst), .adr_i(adr), .dat_i(dat_w), .dat_o(dat_r), .we_i(we),
    .sel_i(sel), .stb_i(stb), .cyc_i(cyc), .ack_o(ack), .gpio_i(pads),
    .gpio_o(gout), .gpio_oe_o(goe), .irq_o(irq)
  );

  // Reference model state
  logic        m_ack = 1'b0;
  logic [31:0] m_dat = '0;
  logic [7:0]  m_out = 8'hA5;
  logic [7:0]  m_dir = 8'h00;
  logic        m_irq = 1'b0;
  logic [7:0]  hist[$];
`ifdef GPIO_IRQ_EN
  logic [7:0]  m_rise = '0, m_fall = '0, m_stat = '0, m_prev = '0;
`endif

  always @(posedge clk) begin : ref_model
    logic [7:0]  in_b;
    logic [31:0] rv;
`ifdef GPIO_IRQ_EN
    logic [7:0]  clr, ev;
`endif
    if (rst) begin
      m_ack = 0; m_dat = 0; m_out = 8'hA5; m_dir = 0; m_irq = 0;
      hist.delete();
      repeat (SS) hist.push_back(8'h00);
`ifdef GPIO_IRQ_EN
      m_rise = 0; m_fall = 0; m_stat = 0; m_prev = 0;
`endif
    end else begin
      in_b = hist[0];
      rv = 0;
`ifdef GPIO_IRQ_EN
      clr = 0;
      ev = (in_b & ~m_prev & m_rise) | (~in_b & m_prev & m_fall);
`endif
      if (cyc && stb && !m_ack) begin
        case (adr[5:2])
          4'd0: rv = {24'b0, in_b};
          4'd1: rv = {24'b0, m_out};
          4'd2: rv = {24'b0, m_dir};
`ifdef GPIO_IRQ_EN
          4'd6: rv = {24'b0, m_rise};
          4'd7: rv = {24'b0, m_fall};
          4'd8: rv = {24'b0, m_stat};
`endif
          default: rv = 0;
        endcase
        if (we) begin
          case (adr[5:2])
            4'd1: if (sel[0]) m_out = dat_w[7:0];
            4'd2: if (sel[0]) m_dir = dat_w[7:0];
            4'd3: m_out = m_out | dat_w[7:0];
            4'd4: m_out = m_out & ~dat_w[7:0];
            4'd5: m_out = m_out ^ dat_w[7:0];
`ifdef GPIO_IRQ_EN
            4'd6: if (sel[0]) m_rise = dat_w[7:0];
            4'd7: if (sel[0]) m_fall = dat_w[7:0];
            4'd8: clr = dat_w[7:0];
`endif
            default: ;
          endcase
        end
        m_ack = 1; m_dat = rv;
      end else begin
        m_ack = 0; m_dat = 0;
      end
`ifdef GPIO_IRQ_EN
      m_stat = (m_stat & ~clr) | ev;
      m_irq  = |m_stat;
      m_prev = in_b;
`endif
      hist.push_back(pads);
      void'(hist.pop_front());
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".ack"},  {31'b0, ack}, {31'b0, m_ack});
    chk({tag, ".dat"},  dat_r, m_dat);
    chk({tag, ".out"},  {24'b0, gout}, {24'b0, m_out});
    chk({tag, ".oe"},   {24'b0, goe}, {24'b0, m_dir});
    chk({tag, ".irq"},  {31'b0, irq}, {31'b0, m_irq});
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      tick();
      check_all("idle");
    end
  endtask

  task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, output logic [31:0] rd);
    cyc = 1; stb = 1; we = w; adr = a; dat_w = d; sel = s;
    tick();
    chk("ack_rise", {31'b0, ack}, 32'd1);
    check_all("acc");
    rd = dat_r;
    cyc = 0; stb = 0; we = 0;
    tick();
    chk("ack_one_cycle", {31'b0, ack}, 32'd0);
    chk("dat_idle_zero", dat_r, 32'd0);
    check_all("post");
  endtask

  initial begin
    logic [31:0] rd;
    int hold;

    // Reset values
    tick();
    tick();
    chk("rst.out", {24'b0, gout}, 32'hA5);
    chk("rst.oe", {24'b0, goe}, 32'h00);
    chk("rst.irq", {31'b0, irq}, 32'd0);
    chk("rst.ack", {31'b0, ack}, 32'd0);
    chk("rst.dat", dat_r, 32'd0);
    rst = 0;
    idle(1);

    // OUT and atomic set/clear/toggle (sel ignored on the atomic registers)
    access(1, 32'h04, 32'h0F, 4'hF, rd); chk("out_write", {24'b0, gout}, 32'h0F);
    access(1, 32'h0C, 32'hF0, 4'h0, rd); chk("out_set", {24'b0, gout}, 32'hFF);
    access(1, 32'h10, 32'h03, 4'h0, rd); chk("out_clr", {24'b0, gout}, 32'hFC);
    access(1, 32'h14, 32'h81, 4'h0, rd); chk("out_tgl", {24'b0, gout}, 32'h7D);
    access(0, 32'h0C, 32'h0, 4'hF, rd);  chk("set_reads_zero", rd, 32'h0);

    // DIR with byte-lane select and upper bits dropped
    access(1, 32'h08, 32'h1234_00FF, 4'b0001, rd); chk("dir_write", {24'b0, goe}, 32'hFF);
    access(0, 32'h08, 32'h0, 4'hF, rd);            chk("dir_read", rd, 32'h0000_00FF);
    access(1, 32'h08, 32'h0000_0000, 4'b0010, rd); chk("dir_lane_masked", {24'b0, goe}, 32'hFF);

    // Synchroniser latency, and an unmapped register
    pads = 8'h3C;
    access(0, 32'h00, 32'h0, 4'hF, rd); chk("in_early", rd, 32'h00);
    access(0, 32'h00, 32'h0, 4'hF, rd); chk("in_late", rd, 32'h3C);
    access(0, 32'h30, 32'h0, 4'hF, rd); chk("unmapped_read", rd, 32'h0);
    access(1, 32'hFFFF_FF3C, 32'hFFFF_FFFF, 4'hF, rd); chk("unmapped_write", {24'b0, gout}, 32'h7D);

`ifdef GPIO_IRQ_EN
    access(1, 32'h18, 32'h01, 4'hF, rd);
    access(1, 32'h1C, 32'h02, 4'hF, rd);
    pads = 8'h3E; idle(4);
    access(0, 32'h20, 0, 4'hF, rd); chk("stat_unmasked_rise", rd, 32'h00);
    pads = 8'h3F; idle(4);
    access(0, 32'h20, 0, 4'hF, rd); chk("stat_rise", rd, 32'h01);
    chk("irq_set", {31'b0, irq}, 32'd1);
    pads = 8'h3D; idle(4);
    access(0, 32'h20, 0, 4'hF, rd); chk("stat_fall", rd, 32'h03);
    pads = 8'h3C; idle(4);
    pads = 8'h3D; tick(); check_all("pre"); tick(); check_all("pre");
    access(1, 32'h20, 32'h01, 4'hF, rd);
    access(0, 32'h20, 0, 4'hF, rd); chk("stat_set_wins", rd, 32'h03);
    access(1, 32'h20, 32'h03, 4'hF, rd);
    chk("irq_clear", {31'b0, irq}, 32'd0);
    access(0, 32'h20, 0, 4'hF, rd); chk("stat_cleared", rd, 32'h00);
`else
    access(1, 32'h18, 32'hFF, 4'hF, rd);
    access(0, 32'h18, 0, 4'hF, rd); chk("rise_absent", rd, 32'h0);
    access(1, 32'h1C, 32'hFF, 4'hF, rd);
    access(0, 32'h1C, 0, 4'hF, rd); chk("fall_absent", rd, 32'h0);
    pads = 8'hC3; idle(4);
    access(0, 32'h20, 0, 4'hF, rd); chk("stat_absent", rd, 32'h0);
    chk("irq_tied", {31'b0, irq}, 32'd0);
`endif

    // Reset lands on the edge that would acknowledge a write
    cyc = 1; stb = 1; we = 1; adr = 32'h04; dat_w = 32'h00; sel = 4'hF; rst = 1;
    tick();
    chk("rst_mid.ack", {31'b0, ack}, 32'd0);
    chk("rst_mid.out", {24'b0, gout}, 32'hA5);
    rst = 0; cyc = 0; stb = 0; we = 0;
    idle(1);
    access(1, 32'h04, 32'h55, 4'hF, rd); chk("after_rst_write", {24'b0, gout}, 32'h55);

    // Random traffic, including requests held across the acknowledge
    repeat (300) begin
      cyc = 1; stb = 1; we = 1'($urandom);
      adr = $urandom; dat_w = $urandom; sel = 4'($urandom);
      if ($urandom_range(0, 3) == 0) adr[5:2] = 4'd8;
      hold = $urandom_range(1, 3);
      repeat (hold) begin
        if ($urandom_range(0, 2) == 0) pads = 8'($urandom);
        tick();
        check_all("rnd");
      end
      cyc = 0; stb = 0; we = 0;
      repeat ($urandom_range(0, 2)) begin
        if ($urandom_range(0, 2) == 0) pads = 8'($urandom);
        tick();
        check_all("rnd_gap");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
